// File: rtl/intc_if.sv
// Register-port bundle between the kernel data bus and the interrupt controller.
// Single-cycle strobe in; ack and read data come back registered one cycle later.
interface intc_if;
   logic        bus_req;
   logic        bus_we;
   logic [1:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_rdata,
      input  bus_ack
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_rdata,
      output bus_ack
   );
endinterface

// File: rtl/intc.sv
// External interrupt controller feeding the CP0 hardware interrupt vector.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on every irq_in bit.
module intc #(
   parameter int NLINES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NLINES-1:0] irq_in,
   output logic [7:0]        ints_out,
   intc_if.slave             bus
);

   localparam logic [7:0] LINE_MASK    = 8'hFF >> (8 - NLINES);
   localparam logic [1:0] ADDR_PENDING = 2'd0;
   localparam logic [1:0] ADDR_ENABLE  = 2'd1;
   localparam logic [1:0] ADDR_MODE    = 2'd2;
   localparam logic [1:0] ADDR_CLAIM   = 2'd3;

   // Highest requesting line wins; bit 31 flags a valid claim.
   function automatic logic [31:0] claim_word(input logic [7:0] req);
      logic [31:0] w;
      w = 32'h0000_0000;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) begin
            w = {1'b1, 28'h000_0000, i[2:0]};
         end
      end
      return w;
   endfunction

   logic [7:0]  irq_ext_s;
   logic [7:0]  event_s;
   logic [7:0]  prev_r;
   logic [7:0]  pending_r;
   logic [7:0]  enable_r;
   logic [7:0]  mode_r;
   logic [7:0]  ints_r;
   logic        ack_r;
   logic [31:0] rdata_r;
   logic [7:0]  pending_nxt_s;
   logic [7:0]  rise_s;
   logic [7:0]  w1c_s;
   logic [7:0]  claim_hit_s;
   logic [31:0] claim_word_s;
   logic [31:0] read_data_s;
   logic        rd_s;
   logic        wr_s;
   logic [23:0] wdata_unused_s;

   assign wdata_unused_s = bus.bus_wdata[31:8];

   // Widen the implemented request lines to the full 8-bit vector.
   always_comb begin
      irq_ext_s = 8'h00;
      for (int i = 0; i < NLINES; i++) begin
         irq_ext_s[i] = irq_in[i];
      end
   end

`ifdef INTC_SYNC_EN
   logic [7:0] sync1_r;
   logic [7:0] sync2_r;

   // Two-flop synchronizer for asynchronous peripheral requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 8'h00;
         sync2_r <= 8'h00;
      end else begin
         sync1_r <= irq_ext_s;
         sync2_r <= sync1_r;
      end
   end

   assign event_s = sync2_r;
`else
   assign event_s = irq_ext_s;
`endif

   assign rd_s         = bus.bus_req & ~bus.bus_we;
   assign wr_s         = bus.bus_req &  bus.bus_we;
   assign rise_s       = event_s & ~prev_r;
   assign claim_word_s = claim_word(pending_r & enable_r);

   // Decode the side effects of this cycle's access on PENDING.
   always_comb begin
      w1c_s       = 8'h00;
      claim_hit_s = 8'h00;
      if (wr_s && (bus.bus_addr == ADDR_PENDING)) begin
         w1c_s = bus.bus_wdata[7:0];
      end else begin
         w1c_s = 8'h00;
      end
      if (rd_s && (bus.bus_addr == ADDR_CLAIM) && claim_word_s[31]) begin
         claim_hit_s = 8'h01 << claim_word_s[2:0];
      end else begin
         claim_hit_s = 8'h00;
      end
   end

   // Read mux over pre-update register values.
   always_comb begin
      read_data_s = 32'h0000_0000;
      case (bus.bus_addr)
         ADDR_PENDING: read_data_s = {24'h00_0000, pending_r};
         ADDR_ENABLE:  read_data_s = {24'h00_0000, enable_r};
         ADDR_MODE:    read_data_s = {24'h00_0000, mode_r};
         ADDR_CLAIM:   read_data_s = claim_word_s;
         default:      read_data_s = 32'h0000_0000;
      endcase
   end

   // Per-line pending update: edge lines are sticky with set over clear, level lines track the source.
   always_comb begin
      pending_nxt_s = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (mode_r[i]) begin
            if (rise_s[i]) begin
               pending_nxt_s[i] = 1'b1;
            end else if (w1c_s[i] || claim_hit_s[i]) begin
               pending_nxt_s[i] = 1'b0;
            end else begin
               pending_nxt_s[i] = pending_r[i];
            end
         end else begin
            pending_nxt_s[i] = event_s[i];
         end
      end
      pending_nxt_s = pending_nxt_s & LINE_MASK;
   end

   // Controller state, CP0 vector and registered bus response.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r    <= 8'h00;
         pending_r <= 8'h00;
         enable_r  <= 8'h00;
         mode_r    <= 8'h00;
         ints_r    <= 8'h00;
         ack_r     <= 1'b0;
         rdata_r   <= 32'h0000_0000;
      end else begin
         prev_r    <= event_s;
         pending_r <= pending_nxt_s;
         ints_r    <= pending_r & enable_r;
         ack_r     <= bus.bus_req;
         rdata_r   <= rd_s ? read_data_s : 32'h0000_0000;
         if (wr_s && (bus.bus_addr == ADDR_ENABLE)) begin
            enable_r <= bus.bus_wdata[7:0] & LINE_MASK;
         end
         if (wr_s && (bus.bus_addr == ADDR_MODE)) begin
            mode_r <= bus.bus_wdata[7:0] & LINE_MASK;
         end
      end
   end

   assign ints_out      = ints_r;
   assign bus.bus_ack   = ack_r;
   assign bus.bus_rdata = rdata_r;

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: vector table, directed corner sequences and
// randomized traffic compared against a behavioural model of the controller.
module tb_intc;

   localparam int NLINES = 8;
`ifdef INTC_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq;
   logic [7:0] ints_out;

   intc_if bus ();

   intc #(.NLINES(NLINES)) dut (
      .clk      (clk),
      .rst      (rst),
      .irq_in   (irq),
      .ints_out (ints_out),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [7:0]  m_pend, m_en, m_mode, m_prev, m_ints;
   logic        m_ack;
   logic [31:0] m_rdata;
   logic [7:0]  sync_q[$];

   typedef struct {
      logic [7:0]  irq;
      logic        req;
      logic        we;
      logic [1:0]  addr;
      logic [7:0]  wdata;
      logic        chk_ints;
      logic [7:0]  ints;
      logic        ack;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   // One rising edge of the model, using the inputs currently driven.
   task automatic model_edge();
      logic [7:0]  s, claimed, w1c, req_m;
      logic [31:0] cw;
      if (rst) begin
         m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00; m_prev = 8'h00;
         m_ints = 8'h00; m_ack = 1'b0; m_rdata = 32'h0;
         sync_q.delete();
         repeat (LAT) sync_q.push_back(8'h00);
      end else begin
         if (LAT == 0) s = irq;
         else begin
            s = sync_q.pop_front();
            sync_q.push_back(irq);
         end
         req_m = m_pend & m_en;
         cw = 32'h0;
         for (int i = 7; i >= 0; i--)
            if (req_m[i] && !cw[31]) cw = 32'h8000_0000 | 32'(i);
         claimed = 8'h00;
         if (bus.bus_req && !bus.bus_we && bus.bus_addr == 2'd3 && cw[31])
            claimed[cw[2:0]] = 1'b1;
         w1c = (bus.bus_req && bus.bus_we && bus.bus_addr == 2'd0) ? bus.bus_wdata[7:0] : 8'h00;
         m_ints = m_pend & m_en;
         m_ack = bus.bus_req;
         m_rdata = 32'h0;
         if (bus.bus_req && !bus.bus_we) begin
            case (bus.bus_addr)
               2'd0: m_rdata = 32'(m_pend);
               2'd1: m_rdata = 32'(m_en);
               2'd2: m_rdata = 32'(m_mode);
               default: m_rdata = cw;
            endcase
         end
         for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
               if (s[i] && !m_prev[i]) m_pend[i] = 1'b1;
               else if (w1c[i] || claimed[i]) m_pend[i] = 1'b0;
            end else begin
               m_pend[i] = s[i];
            end
         end
         m_prev = s;
         if (bus.bus_req && bus.bus_we && bus.bus_addr == 2'd1) m_en = bus.bus_wdata[7:0];
         if (bus.bus_req && bus.bus_we && bus.bus_addr == 2'd2) m_mode = bus.bus_wdata[7:0];
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("model_ints", 32'(ints_out), 32'(m_ints));
      chk("model_ack", 32'(bus.bus_ack), 32'(m_ack));
      chk("model_rdata", bus.bus_rdata, m_rdata);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic access(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
      bus.bus_req = 1'b1; bus.bus_we = we; bus.bus_addr = addr; bus.bus_wdata = wdata;
      step();
      rdata = bus.bus_rdata;
      bus.bus_req = 1'b0; bus.bus_we = 1'b0; bus.bus_wdata = 32'h0;
   endtask

   function automatic vec_t mk(input logic [7:0] i, input logic rq, input logic w, input logic [1:0] a,
                               input logic [7:0] wd, input logic ci, input logic [7:0] ei,
                               input logic ea, input logic [31:0] er);
      vec_t v;
      v.irq = i; v.req = rq; v.we = w; v.addr = a; v.wdata = wd;
      v.chk_ints = ci; v.ints = ei; v.ack = ea; v.rdata = er;
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;

      // Level-mode claim scenario, settle gaps cover either sync latency
      tbl.push_back(mk(8'h00, 1'b1, 1'b1, 2'd1, 8'hFF, 1'b1, 8'h00, 1'b1, 32'h0));
      tbl.push_back(mk(8'h24, 1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b1, 32'h0000_00FF));
      tbl.push_back(mk(8'h24, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0));
      tbl.push_back(mk(8'h24, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0));
      tbl.push_back(mk(8'h24, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 8'h24, 1'b0, 32'h0));
      tbl.push_back(mk(8'h24, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h24, 1'b1, 32'h8000_0005));
      tbl.push_back(mk(8'h24, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h24, 1'b1, 32'h0000_0024));
      tbl.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0));
      tbl.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0));
      tbl.push_back(mk(8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0));
      tbl.push_back(mk(8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b1, 32'h0));
      tbl.push_back(mk(8'h00, 1'b1, 1'b1, 2'd2, 8'hFF, 1'b1, 8'h00, 1'b1, 32'h0));
      tbl.push_back(mk(8'h00, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h00, 1'b1, 32'h0000_00FF));
      tbl.push_back(mk(8'h00, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h00, 1'b1, 32'h0));
      tbl.push_back(mk(8'h00, 1'b1, 1'b1, 2'd0, 8'hFF, 1'b1, 8'h00, 1'b1, 32'h0));
      tbl.push_back(mk(8'h00, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b1, 8'h00, 1'b1, 32'h0));
      tbl.push_back(mk(8'h00, 1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b1, 32'h0000_00FF));

      rst = 1'b1; irq = 8'h00;
      bus.bus_req = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 2'd0; bus.bus_wdata = 32'h0;
      idle(3);
      rst = 1'b0;
      step();
      chk("reset_ack", 32'(bus.bus_ack), 32'h0);
      chk("reset_ints", 32'(ints_out), 32'h0);

      // Reset state of all four registers
      for (int a = 0; a < 4; a++) begin
         access(1'b0, 2'(a), 32'h0, rd);
         chk("reset_read_ack", 32'(bus.bus_ack), 32'h1);
         chk("reset_read", rd, 32'h0);
         chk("reset_read_ints", 32'(ints_out), 32'h0);
      end

      foreach (tbl[k]) begin
         irq = tbl[k].irq;
         bus.bus_req = tbl[k].req; bus.bus_we = tbl[k].we;
         bus.bus_addr = tbl[k].addr; bus.bus_wdata = 32'(tbl[k].wdata);
         step();
         if (tbl[k].chk_ints) chk("tbl_ints", 32'(ints_out), 32'(tbl[k].ints));
         chk("tbl_ack", 32'(bus.bus_ack), 32'(tbl[k].ack));
         chk("tbl_rdata", bus.bus_rdata, tbl[k].rdata);
      end
      bus.bus_req = 1'b0; bus.bus_we = 1'b0; irq = 8'h00;

      rst = 1'b1; step(); rst = 1'b0;

      // One-cycle pulse on an edge line, sticky until W1C
      access(1'b1, 2'd2, 32'h01, rd);
      access(1'b1, 2'd1, 32'h01, rd);
      irq = 8'h01;
      for (int e = 1; e <= LAT + 4; e++) begin
         step();
         if (e == 1) irq = 8'h00;
         chk("pulse_ints", 32'(ints_out), (e >= LAT + 2) ? 32'h1 : 32'h0);
      end
      access(1'b1, 2'd0, 32'h01, rd);
      chk("w1c_ints_same", 32'(ints_out), 32'h1);
      step();
      chk("w1c_ints_next", 32'(ints_out), 32'h0);

      // Edges on lines 2 and 6, claimed highest first
      access(1'b1, 2'd2, 32'hFF, rd);
      access(1'b1, 2'd1, 32'hFF, rd);
      irq = 8'h44; step(); irq = 8'h00;
      idle(LAT + 2);
      access(1'b0, 2'd3, 32'h0, rd); chk("claim_6", rd, 32'h8000_0006);
      access(1'b0, 2'd3, 32'h0, rd); chk("claim_2", rd, 32'h8000_0002);
      access(1'b0, 2'd3, 32'h0, rd); chk("claim_none", rd, 32'h0);

      // W1C colliding with a fresh edge on line 3: set wins
      irq = 8'h08; step(); irq = 8'h00;
      idle(LAT + 2);
      access(1'b0, 2'd0, 32'h0, rd); chk("pend3_before", rd, 32'h08);
      irq = 8'h08;
      idle(LAT);
      access(1'b1, 2'd0, 32'h08, rd);
      irq = 8'h00;
      idle(LAT + 1);
      access(1'b0, 2'd0, 32'h0, rd); chk("pend3_set_wins", rd, 32'h08);
      access(1'b1, 2'd0, 32'h08, rd);
      access(1'b0, 2'd0, 32'h0, rd); chk("pend3_cleared", rd, 32'h0);

      // Pending but disabled line, then enable it
      access(1'b1, 2'd1, 32'h00, rd);
      irq = 8'h02; step(); irq = 8'h00;
      idle(LAT + 2);
      chk("disabled_ints", 32'(ints_out), 32'h0);
      access(1'b0, 2'd3, 32'h0, rd); chk("disabled_claim", rd, 32'h0);
      access(1'b0, 2'd0, 32'h0, rd); chk("disabled_pend", rd, 32'h02);
      access(1'b1, 2'd1, 32'h02, rd);
      chk("enable_ints_same", 32'(ints_out), 32'h0);
      step();
      chk("enable_ints_next", 32'(ints_out), 32'h02);

      // Reset mid-access drops the ack
      bus.bus_req = 1'b1; bus.bus_addr = 2'd1;
      step();
      chk("pre_rst_ack", 32'(bus.bus_ack), 32'h1);
      bus.bus_req = 1'b0; rst = 1'b1;
      step();
      chk("rst_ack", 32'(bus.bus_ack), 32'h0);
      chk("rst_ints", 32'(ints_out), 32'h0);
      bus.bus_req = 1'b1;
      step();
      bus.bus_req = 1'b0; rst = 1'b0;
      chk("rst_req_ack", 32'(bus.bus_ack), 32'h0);
      step();
      chk("post_rst_ack", 32'(bus.bus_ack), 32'h0);

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
         bus.bus_req = 1'($urandom);
         bus.bus_we = 1'($urandom);
         bus.bus_addr = 2'($urandom);
         bus.bus_wdata = $urandom;
         step();
      end
      rst = 1'b0; bus.bus_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/intc.md
# intc

External interrupt controller that drives the 8-bit hardware interrupt vector into the coprocessor-0 interrupt input (`ints_in`). It synchronizes raw peripheral request lines, detects level or rising-edge events per line, and holds pending state. Enabled pending lines are presented to CP0 as registered levels. Software configures the controller, acknowledges events, and claims them through a small single-cycle memory-mapped register port on the kernel data bus.

## Interface
- `NLINES`, default 8, is the number of implemented request lines (1..8). Bits at index `NLINES` and above of every register and of `ints_out` read as 0.
- `clk`  in  1  is the clock.
- `rst`  in  1  is the reset: synchronous, active-high, on clock `clk`.
- `irq_in`  in  `NLINES`  carries raw peripheral requests. They are asynchronous when `INTC_SYNC_EN` is defined.
- `ints_out`  out  8  is the registered interrupt vector to CP0 `ints_in`. Bit i = PENDING[i] & ENABLE[i].
- `bus_req`  in  1  is the access strobe: one access per cycle it is high.
- `bus_we`  in  1  selects write (1) or read (0).
- `bus_addr`  in  2  is the word select: 0 = PENDING, 1 = ENABLE, 2 = MODE, 3 = CLAIM.
- `bus_wdata`  in  32  is the write data. Only [7:0] is used.
- `bus_rdata`  out  32  is the read data. It is valid while `bus_ack` is high and 0 otherwise.
- `bus_ack`  out  1  is high exactly one cycle after each `bus_req` cycle.

## Operation
- Registers: PENDING[7:0], ENABLE[7:0], MODE[7:0] (1 = edge, 0 = level). All reset to 0. Read data is zero-extended to 32 bits.
- The per-line event source `s` is the synchronized `irq_in` (or raw `irq_in` without the macro). `prev` is `s` delayed one cycle, with reset value 0.
- Edge line (MODE=1):
  - PENDING[i] sets when s & ~prev.
  - PENDING[i] clears on a W1C write to PENDING, or on a CLAIM read returning i.
  - Set has priority over clear in the same cycle.
- Level line (MODE=0): PENDING[i] <= s every cycle. W1C writes and claims have no effect.
- Mode change takes effect on the next cycle. Switching edge to level discards the sticky state; pending follows `s`.
- Write PENDING: W1C, data bit i=1 clears edge line i.
- Writes to ENABLE and MODE replace the register with wdata[7:0]. A write to CLAIM is ignored, but it is still acked.
- CLAIM read:
  - Returns {valid in bit 31, zeros, index in [2:0]} for the highest index i with PENDING[i] & ENABLE[i].
  - If there is none, it returns 0 and has no side effect.
  - The claimed edge line is cleared in the same cycle the read is accepted.
- Reads return the register values before that cycle's update.
- A line held high through reset in edge mode produces one edge event after reset release, because `prev` resets to 0.

## Timing
- Reset values: `ints_out` = 0, `bus_ack` = 0, `bus_rdata` = 0, synchronizer flops = 0.
- Bus: `bus_ack`/`bus_rdata` are registered one cycle after the `bus_req` edge. Back-to-back requests on consecutive cycles are allowed, and each is acked one cycle later. There is no wait state or backpressure.
- Request latency, counting the first rising edge that samples `irq_in` high as edge 1: PENDING is set at edge 3 and `ints_out` at edge 4 with the macro, or PENDING at edge 1 and `ints_out` at edge 2 without it.
- Clear latency: a W1C or claim accepted at edge k clears PENDING at k, and `ints_out` drops at edge k+1.
- An ENABLE write at edge k is reflected in `ints_out` at edge k+1.
- Reset mid-access: the pending ack is dropped, and `bus_ack` is 0 in the cycle after reset.

## Configuration
- `INTC_SYNC_EN`:
  - Defined: each `irq_in` bit passes through a 2-flop synchronizer before `prev`/edge detection, giving +2 cycles of latency.
  - Undefined: `irq_in` is assumed synchronous to `clk` and feeds edge detection directly.
  - Bus behaviour is identical in both builds.

## Test plan
- Reset, then read all four registers: each read returns 0x00000000 with `bus_ack` one cycle after req, and `ints_out` = 0.
- MODE=0x01, ENABLE=0x01, 1-cycle pulse on `irq_in[0]`: `ints_out[0]`=1 at edge 4 (macro) or edge 2 (no macro). It stays high after the pulse until a W1C write of 0x01 to PENDING, then drops one cycle later.
- Level mode with ENABLE=0xFF and `irq_in`=0x24 held: CLAIM read returns 0x80000005 and PENDING stays 0x24. Dropping `irq_in` clears PENDING within the sync latency.
- Edge mode, ENABLE=0xFF, edges on lines 2 and 6: CLAIM returns 0x80000006, then 0x80000002, then 0x00000000.
- A W1C to line 3 in the same cycle as a new edge on line 3: PENDING[3] remains 1.
- ENABLE=0x00 with line 1 pending: `ints_out`=0 and CLAIM returns 0. Writing ENABLE=0x02 makes `ints_out[1]`=1 on the next cycle.
